// File: rtl/neo_strand_ctrl_gen2_if.sv
// neo_strand_ctrl_gen2_if: host load/send handshake and strand output bundle
interface neo_strand_ctrl_gen2_if #(
    parameter int PIX_W = 3
);
    logic [7:0]       color_level;
    logic [1:0]       color_index;
    logic [PIX_W-1:0] pixel_index;
    logic             load_color;
    logic             send_it;
    logic             neo_data;
    logic             ready_to_load;
    logic             ready_to_send;
    logic             busy;

    modport master (
        output color_level, color_index, pixel_index, load_color, send_it,
        input  neo_data, ready_to_load, ready_to_send, busy
    );

    modport slave (
        input  color_level, color_index, pixel_index, load_color, send_it,
        output neo_data, ready_to_load, ready_to_send, busy
    );
endinterface

// File: rtl/neo_strand_ctrl_gen2.sv
// neo_strand_ctrl_gen2: NeoPixel strand serialiser with pixel store; NEO_DOUBLE_BUFFER_EN adds a back buffer
module neo_strand_ctrl_gen2 #(
    parameter int NUM_PIXELS   = 5,
    parameter int COLOR_CH     = 3,
    parameter int T1H          = 35,
    parameter int T1L          = 30,
    parameter int T0H          = 18,
    parameter int T0L          = 40,
    parameter int LATCH_CYCLES = 2500
) (
    input logic                   clock,
    input logic                   reset,
    neo_strand_ctrl_gen2_if.slave bus
);
    localparam int NBYTES = NUM_PIXELS * COLOR_CH;
    localparam int NBITS  = NBYTES * 8;
    localparam int BW     = $clog2(NBITS);
    localparam int AW     = $clog2(NBYTES);
    localparam int TA     = T1H > T1L ? T1H : T1L;
    localparam int TB     = T0H > T0L ? T0H : T0L;
    localparam int TC     = TA > TB ? TA : TB;
    localparam int TMAX   = TC > LATCH_CYCLES ? TC : LATCH_CYCLES;
    localparam int CW     = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t          state_q;
    logic [BW-1:0]   bit_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      byte_q;
    logic            neo_q;
    // Bytes stored in wire order: pixel*COLOR_CH + slot, slot 0=G 1=R 2=B 3=W
    logic [7:0]      mem_q [NBYTES];
`ifdef NEO_DOUBLE_BUFFER_EN
    logic [7:0]      front_q [NBYTES];
`endif

    logic [1:0]      slot_d;
    logic [AW-1:0]   wr_addr_d;
    logic [AW-1:0]   nxt_addr_d;
    logic [7:0]      nxt_byte_d;
    logic            wr_en_d;
    logic            accept_d;
    logic            rdy_load_d;
    logic            last_d;
    logic [CW-1:0]   hi_last_d;
    logic [CW-1:0]   lo_last_d;

    // Write decode, next-byte fetch and per-bit timing limits
    always_comb begin
        slot_d     = bus.color_index == 2'd2 ? 2'd0 : bus.color_index == 2'd3 ? 2'd3 : bus.color_index + 2'd1;
        wr_addr_d  = AW'(int'(bus.pixel_index) * COLOR_CH + int'(slot_d));
`ifdef NEO_DOUBLE_BUFFER_EN
        rdy_load_d = 1'b1;
`else
        rdy_load_d = state_q == IDLE || state_q == LATCH;
`endif
        wr_en_d    = bus.load_color && rdy_load_d && int'(bus.pixel_index) < NUM_PIXELS
                     && (COLOR_CH == 4 || bus.color_index != 2'd3);
        accept_d   = state_q == IDLE && bus.send_it;
        nxt_addr_d = AW'(int'(bit_q[BW-1:3]) + 1);
`ifdef NEO_DOUBLE_BUFFER_EN
        nxt_byte_d = front_q[nxt_addr_d];
`else
        nxt_byte_d = mem_q[nxt_addr_d];
`endif
        last_d     = bit_q == BW'(NBITS - 1);
        hi_last_d  = byte_q[7] ? CW'(T1H - 1) : CW'(T0H - 1);
        lo_last_d  = byte_q[7] ? CW'(T1L - 1) : CW'(T0L - 1);
    end

    // Pixel store: host writes, and the back-to-front snapshot when a frame starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem_q[i] <= '0;
`ifdef NEO_DOUBLE_BUFFER_EN
                front_q[i] <= '0;
`endif
            end
        end else begin
`ifdef NEO_DOUBLE_BUFFER_EN
            if (accept_d)
                for (int i = 0; i < NBYTES; i++) front_q[i] <= mem_q[i];
`endif
            if (wr_en_d) mem_q[wr_addr_d] <= bus.color_level;
        end
    end

    // Serialiser FSM; the first byte is captured from the pre-write store so a coincident load does not leak into it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            neo_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept_d) begin
                    state_q <= HIGH;
                    neo_q   <= 1'b1;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    byte_q  <= mem_q[0];
                end
                HIGH: if (cnt_q == hi_last_d) begin
                    state_q <= LOW;
                    neo_q   <= 1'b0;
                    cnt_q   <= '0;
                end else cnt_q <= cnt_q + 1'b1;
                LOW: if (cnt_q == lo_last_d) begin
                    cnt_q <= '0;
                    if (last_d) begin
                        state_q <= LATCH;
                        bit_q   <= '0;
                    end else begin
                        state_q <= HIGH;
                        neo_q   <= 1'b1;
                        bit_q   <= bit_q + 1'b1;
                        byte_q  <= bit_q[2:0] == 3'd7 ? nxt_byte_d : {byte_q[6:0], 1'b0};
                    end
                end else cnt_q <= cnt_q + 1'b1;
                LATCH: if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.neo_data      = neo_q;
    assign bus.ready_to_send = state_q == IDLE;
    assign bus.busy          = state_q != IDLE;
    assign bus.ready_to_load = rdy_load_d;
endmodule

// File: doc/neo_strand_ctrl_gen2.md
NEO_STRAND_CTRL_GEN2 -- requirements
Module: neo_strand_ctrl_gen2

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 5, pixels on strand (1..256).
REQ-002 SHALL have parameter COLOR_CH, default 3, channels per pixel (3 = GRB, 4 = GRBW).
REQ-003 SHALL have parameter T1H, default 35, one-bit high cycles.
REQ-004 SHALL have parameter T1L, default 30, one-bit low cycles.
REQ-005 SHALL have parameter T0H, default 18, zero-bit high cycles.
REQ-006 SHALL have parameter T0L, default 40, zero-bit low cycles.
REQ-007 SHALL have parameter LATCH_CYCLES, default 2500, post-frame low time.
REQ-008 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-009 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-010 SHALL have ports: color_level  in  8  channel value to load.
REQ-011 SHALL have ports: color_index  in  2  channel select, 0=R, 1=B, 2=G, 3=W.
REQ-012 SHALL have ports: pixel_index  in  PIX_W=max(1,$clog2(NUM_PIXELS))  target pixel.
REQ-013 SHALL have ports: load_color  in  1  write strobe, one write per cycle.
REQ-014 SHALL have ports: send_it  in  1  frame start request.
REQ-015 SHALL have ports: neo_data  out  1  serial strand output.
REQ-016 SHALL have ports: ready_to_load  out  1, ready_to_send  out  1, busy  out  1 (high in HIGH/LOW/LATCH).

Function
REQ-017 SHALL use states IDLE, HIGH, LOW, LATCH; reset enters IDLE.
REQ-018 SHALL, in IDLE with send_it=1, latch bit 0 of frame and enter HIGH on the next edge; neo_data rises the cycle after send_it sampled.
REQ-019 SHALL hold neo_data=1 in HIGH for exactly T1H (bit=1) or T0H (bit=0) cycles, then LOW.
REQ-020 SHALL hold neo_data=0 in LOW for exactly T1L or T0L cycles, then HIGH for the next bit, or LATCH after the last bit.
REQ-021 SHALL serialise pixel 0 first, per pixel G,R,B then W (COLOR_CH=4), each byte MSB first; frame = NUM_PIXELS*COLOR_CH*8 bits.
REQ-022 SHALL hold neo_data=0 in LATCH for exactly LATCH_CYCLES cycles, then enter IDLE.
REQ-023 SHALL drive ready_to_send=1 only in IDLE; send_it outside IDLE is ignored, not queued.
REQ-024 SHALL, on load_color=1 with ready_to_load=1, write color_level to pixel_index/color_index on that edge.
REQ-025 SHALL ignore writes with pixel_index >= NUM_PIXELS, or color_index=3 when COLOR_CH=3.
REQ-026 SHALL, when load_color and send_it coincide in IDLE, perform the write and start the frame, but transmit the pre-write value.
REQ-027 SHALL size bit and cycle counters from parameters with no overflow; bit counter wraps to 0 only on frame end.
REQ-028 SHALL retain pixel memory across frames; no implicit clear except reset.

Reset
REQ-029 SHALL, on reset=0, asynchronously force IDLE, neo_data=0, busy=0, ready_to_load=1, ready_to_send=1, all counters 0, all pixel channels 0.
REQ-030 SHALL, on reset mid-frame, abort immediately with neo_data=0; no partial bit completion.
REQ-031 SHALL release from reset synchronously on the first rising clock edge after reset=1.

Configuration
REQ-032 SHALL support macro NEO_DOUBLE_BUFFER_EN.
REQ-033 SHALL, with NEO_DOUBLE_BUFFER_EN defined, write into a back buffer at all times (ready_to_load=1 outside reset), copy back to front on send_it acceptance, and transmit only from front.
REQ-034 SHALL, without NEO_DOUBLE_BUFFER_EN, use a single buffer, with ready_to_load=1 only in IDLE and LATCH, dropping loads in HIGH/LOW.

Verification
REQ-035 SHALL cover: reset, load pixel0 G=0x80, send_it -> first bit high 35 cycles, low 30, then seven 0-bits at 18/40.
REQ-036 SHALL cover: NUM_PIXELS=2, all zero, send_it -> 48 bits of 18/40, then 2500 low cycles, ready_to_send=1 after.
REQ-037 SHALL cover: send_it during HIGH -> ignored, single frame only, busy stays 1 until LATCH ends.
REQ-038 SHALL cover: load_color with pixel_index=5, NUM_PIXELS=5 -> memory unchanged, next frame all zeros.
REQ-039 SHALL cover: reset=0 at bit 60 -> neo_data=0 same cycle, state IDLE, memory zeroed.
REQ-040 SHALL cover: NEO_DOUBLE_BUFFER_EN, load R=0xFF mid-frame -> current frame unaffected, next frame R byte 0xFF.
